// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin front-end sharing one FP adder between two requesters
//
// Optional feature macro: FP_ARB_SUB_EN (when defined, reqN_sub=1 negates b
// so the shared adder computes a - b; when undefined, reqN_sub is ignored).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  per-requester handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_sub per-requester operands and subtract select
//   fpu_a, fpu_b             registered operands to the external adder
//   fpu_out, fpu_uof         adder result and under/overflow flag
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_result,      owner, captured result and flag of the response
//   rsp_flag
//   busy                     high whenever the FSM is not in IDLE
//   ops_done                 completed-response counter (wraps)
module fp_add_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sub,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [31:0]      fpu_out,
  input  logic             fpu_uof,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_flag,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic        ptr;       // requester preferred when both are valid
  logic        id_q;
  logic        grant0, grant1;
  logic [31:0] sel_a, sel_b, sel_b_adj;

  // Next state and grant decision; grants only happen in IDLE.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || !ptr)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The FSM sits in IDLE while reset is held, so ready must be masked explicitly.
  assign req0_ready = grant0 && !rst;
  assign req1_ready = grant1 && !rst;
  assign busy       = (state != IDLE);
  assign rsp_id     = id_q;

  assign sel_a = grant1 ? req1_a : req0_a;
  assign sel_b = grant1 ? req1_b : req0_b;

`ifdef FP_ARB_SUB_EN
  logic sel_sub;
  assign sel_sub   = grant1 ? req1_sub : req0_sub;
  assign sel_b_adj = sel_sub ? {~sel_b[31], sel_b[30:0]} : sel_b;
`else
  logic unused_sub;
  assign unused_sub = req0_sub ^ req1_sub;
  assign sel_b_adj  = sel_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 1'b0;
      id_q       <= 1'b0;
      fpu_a      <= 32'h0;
      fpu_b      <= 32'h0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'h0;
      rsp_flag   <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            fpu_a <= sel_a;
            fpu_b <= sel_b_adj;
            id_q  <= grant1;
            ptr   <= !grant1;  // next tie goes to the loser
          end
        end
        EXEC: begin
          rsp_result <= fpu_out;
          rsp_flag   <= fpu_uof;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
